axis_combine: RTL and testbench

AXI-stream combiner with N slave channels and one master channel. It waits until every slave channel has presented one beat, then emits all N beats together as a single packed master beat. Each channel is buffered independently, so channels may arrive skewed relative to each other. It is the gather end for streams produced by the broadcast distributor, e.g. rejoining N parallel per-channel processing lanes into one wide bus.

---
 rtl/axis_combine.sv | 83 ++++++++
 tb/tb_axis_combine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_combine.sv
// ---------------------------------------------------------------------------
// axis_combine: gathers one beat from each of NUM_COMBINE slave streams into
// a single packed master beat. Each channel has a one-beat skid slot.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axis_combine #(
  parameter int NUM_COMBINE = 6,
  parameter int DATA_WIDTH  = 256,
  localparam int PACKED_WIDTH = NUM_COMBINE * DATA_WIDTH
) (
  input  logic                    s_axis_clk,
  input  logic                    s_axis_rst_n,
  input  logic [NUM_COMBINE-1:0]  s_axis_tvalid,
  output logic [NUM_COMBINE-1:0]  s_axis_tready,
  input  logic [PACKED_WIDTH-1:0] s_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [PACKED_WIDTH-1:0] m_axis_tdata
);

  logic                    r_active;
  logic [NUM_COMBINE-1:0]  r_full;
  logic [PACKED_WIDTH-1:0] r_slot_data;
  logic                    r_m_tvalid;
  logic [PACKED_WIDTH-1:0] r_m_tdata;

  logic [NUM_COMBINE-1:0]  w_ready;
  logic [NUM_COMBINE-1:0]  w_frame;
  logic [NUM_COMBINE-1:0]  w_have;
  logic                    w_out_free;
  logic                    w_load;

  // Ready depends on registered state only, so no tvalid-to-tready path exists.
  assign w_ready    = {NUM_COMBINE{r_active}} & ~r_full;
  assign w_frame    = s_axis_tvalid & w_ready;
  assign w_have     = r_full | w_frame;
  assign w_out_free = ~r_m_tvalid | m_axis_tready;
  assign w_load     = (&w_have) & w_out_free;

  assign s_axis_tready = w_ready;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;

  always_ff @(posedge s_axis_clk or negedge s_axis_rst_n) begin
    if (!s_axis_rst_n) begin
      r_active   <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (w_load) begin
        r_m_tvalid <= 1'b1;
      end else if (r_m_tvalid && m_axis_tready) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  // A channel whose beat arrives on the loading edge bypasses its slot.
  always_ff @(posedge s_axis_clk or negedge s_axis_rst_n) begin
    if (!s_axis_rst_n) begin
      r_full      <= '0;
      r_slot_data <= '0;
      r_m_tdata   <= '0;
    end else begin
      for (int n = 0; n < NUM_COMBINE; n++) begin
        if (w_load) begin
          r_full[n] <= 1'b0;
          r_m_tdata[n*DATA_WIDTH +: DATA_WIDTH] <= r_full[n]
            ? r_slot_data[n*DATA_WIDTH +: DATA_WIDTH]
            : s_axis_tdata[n*DATA_WIDTH +: DATA_WIDTH];
        end else if (w_frame[n]) begin
          r_full[n] <= 1'b1;
          r_slot_data[n*DATA_WIDTH +: DATA_WIDTH] <= s_axis_tdata[n*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_combine.sv
// ---------------------------------------------------------------------------
// tb_axis_combine: vector table, directed corner sequences and a randomized
// soak checked against per-channel beat queues. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axis_combine;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int P    = N * W;
  localparam int SOAK = 2000;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic [N-1:0] tvalid = '0;
  logic [N-1:0] tready;
  logic [P-1:0] tdata  = '0;
  logic         mvalid;
  logic         mready = 1'b0;
  logic [P-1:0] mdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_combine #(.NUM_COMBINE(N), .DATA_WIDTH(W)) dut (
    .s_axis_clk   (clk),
    .s_axis_rst_n (rst_n),
    .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .s_axis_tdata (tdata),
    .m_axis_tvalid(mvalid),
    .m_axis_tready(mready),
    .m_axis_tdata (mdata)
  );

  typedef struct packed {
    logic [N-1:0] v;
    logic [P-1:0] d;
    logic         r;
    logic [N-1:0] e_rdy;
    logic         e_mv;
    logic [P-1:0] e_md;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [P-1:0] act, input logic [P-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stream beat k of every channel: lane n = 0x10*k + n.
  function automatic logic [P-1:0] beat(input int k);
    logic [P-1:0] r;
    r = '0;
    for (int n = 0; n < N; n++) r[n*W +: W] = 8'((k * 16 + n) & 255);
    return r;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           nk [N];
    int           outk;
    logic [P-1:0] held;
    logic [W-1:0] q [N][$];
    int           sent [N];
    int           got;
    int           cyc;
    logic [N-1:0] acc;
    logic         stall;
    logic [P-1:0] stall_data;
    logic [P-1:0] exp_word;
    logic         underflow;

    // ---------------- reset ----------------
    tvalid = '1; tdata = 32'h11223344; mready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", tready, '0);
    check("rst_mvalid", mvalid, '0);
    check("rst_mdata",  mdata,  '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_tready_first_edge", tready, '0);
    @(posedge clk); #1;
    check("rel_tready_second", tready, 4'hF);
    check("rel_no_accept", mvalid, '0);
    tvalid = '0;

    // ---------------- vector table ----------------
    tbl[0]  = '{4'b0001, 32'h000000A0, 1'b1, 4'b1110, 1'b0, 32'h00000000};
    tbl[1]  = '{4'b0000, 32'h00000000, 1'b1, 4'b1110, 1'b0, 32'h00000000};
    tbl[2]  = '{4'b1110, 32'hB3B2B1FF, 1'b1, 4'b1111, 1'b1, 32'hB3B2B1A0};
    tbl[3]  = '{4'b1111, 32'hC3C2C1C0, 1'b0, 4'b0000, 1'b1, 32'hB3B2B1A0};
    tbl[4]  = '{4'b1111, 32'hD3D2D1D0, 1'b0, 4'b0000, 1'b1, 32'hB3B2B1A0};
    tbl[5]  = '{4'b1111, 32'hD3D2D1D0, 1'b1, 4'b1111, 1'b1, 32'hC3C2C1C0};
    tbl[6]  = '{4'b1111, 32'hD3D2D1D0, 1'b1, 4'b1111, 1'b1, 32'hD3D2D1D0};
    tbl[7]  = '{4'b0000, 32'h00000000, 1'b1, 4'b1111, 1'b0, 32'hD3D2D1D0};
    tbl[8]  = '{4'b0011, 32'h0000E1E0, 1'b0, 4'b1100, 1'b0, 32'hD3D2D1D0};
    tbl[9]  = '{4'b1100, 32'hE3E20000, 1'b0, 4'b1111, 1'b1, 32'hE3E2E1E0};
    tbl[10] = '{4'b0000, 32'h00000000, 1'b0, 4'b1111, 1'b1, 32'hE3E2E1E0};
    tbl[11] = '{4'b0000, 32'h00000000, 1'b1, 4'b1111, 1'b0, 32'hE3E2E1E0};
    for (int i = 0; i < 12; i++) begin
      tvalid = tbl[i].v; tdata = tbl[i].d; mready = tbl[i].r;
      @(posedge clk); #1;
      check($sformatf("vec%0d_tready", i), tready, tbl[i].e_rdy);
      check($sformatf("vec%0d_mvalid", i), mvalid, tbl[i].e_mv);
      check($sformatf("vec%0d_mdata",  i), mdata,  tbl[i].e_md);
    end
    tvalid = '0; mready = 1'b1;

    // ---------------- streaming with a backpressure window ----------------
    for (int n = 0; n < N; n++) nk[n] = 0;
    outk = 0; held = '0;
    for (int c = 0; c < 33; c++) begin
      mready = (c < 10 || c >= 20);
      tvalid = (c < 30) ? '1 : '0;
      for (int n = 0; n < N; n++) tdata[n*W +: W] = 8'((nk[n] * 16 + n) & 255);
      @(negedge clk);
      if (c >= 1 && c < 10) begin
        check("stream_mvalid", mvalid, 1'b1);
        check("stream_tready", tready, 4'hF);
      end
      if (c == 10) held = mdata;
      if (c >= 11 && c < 20) begin
        check("bp_tready", tready, '0);
        check("bp_hold", mdata, held);
      end
      if (mvalid && mready) begin
        check($sformatf("stream_out%0d", outk), mdata, beat(outk));
        outk++;
      end
      for (int n = 0; n < N; n++) if (tvalid[n] && tready[n]) nk[n]++;
      @(posedge clk); #1;
    end
    check("stream_count", outk, nk[0]);
    tvalid = '0;

    // ---------------- skewed arrival ----------------
    tvalid = 4'b0001; tdata = 32'h000000A0; mready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 5) begin tvalid = 4'b1110; tdata = 32'hB3B2B100; end
      @(negedge clk);
      if (c >= 1 && c <= 5) check($sformatf("skew_tready0_c%0d", c), tready[0], 1'b0);
      if (c <= 5) check($sformatf("skew_mvalid_c%0d", c), mvalid, 1'b0);
      if (c == 6) begin
        check("skew_mvalid_rise", mvalid, 1'b1);
        check("skew_lane0", mdata[7:0], 8'hA0);
        check("skew_word", mdata, 32'hB3B2B1A0);
        check("skew_tready0_back", tready[0], 1'b1);
      end
      @(posedge clk); #1;
      if (c == 0 || c == 5) tvalid = '0;
    end

    // ---------------- reset mid-operation ----------------
    mready = 1'b0; tvalid = '1; tdata = 32'h01020304;
    @(posedge clk); #1;
    tvalid = 4'b0011; tdata = 32'h00000506;
    @(posedge clk); #1;
    tvalid = '0;
    check("mr_pending", mvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_async_mvalid", mvalid, 1'b0);
    check("mr_async_tready", tready, '0);
    check("mr_async_mdata", mdata, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mready = 1'b1;
    @(posedge clk); #1;
    check("mr_tready_after", tready, 4'hF);
    check("mr_no_replay", mvalid, 1'b0);
    tvalid = '1; tdata = 32'hF3F2F1F0;
    @(posedge clk); #1;
    tvalid = '0;
    check("mr_post_valid", mvalid, 1'b1);
    check("mr_post_data", mdata, 32'hF3F2F1F0);
    @(posedge clk); #1;

    // ---------------- random soak ----------------
    for (int n = 0; n < N; n++) sent[n] = 0;
    got = 0; cyc = 0; stall = 1'b0; stall_data = '0;
    tvalid = '0; mready = 1'b0;
    while (got < SOAK && cyc < 40000) begin
      for (int n = 0; n < N; n++) begin
        if (!tvalid[n] && sent[n] < SOAK && $urandom_range(0, 2) != 0) begin
          tvalid[n] = 1'b1;
          tdata[n*W +: W] = 8'($urandom);
        end
      end
      mready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (stall) check("soak_hold", mdata, stall_data);
      acc = tvalid & tready;
      for (int n = 0; n < N; n++) begin
        if (acc[n]) begin
          q[n].push_back(tdata[n*W +: W]);
          sent[n]++;
        end
      end
      if (mvalid && mready) begin
        underflow = 1'b0;
        exp_word  = '0;
        for (int n = 0; n < N; n++) begin
          if (q[n].size() == 0) underflow = 1'b1;
          else exp_word[n*W +: W] = q[n].pop_front();
        end
        check("soak_no_phantom", underflow, 1'b0);
        check($sformatf("soak_out%0d", got), mdata, exp_word);
        got++;
      end
      stall = mvalid && !mready;
      stall_data = mdata;
      @(posedge clk); #1;
      tvalid = tvalid & ~acc;
      cyc++;
    end
    check("soak_timeout", (cyc < 40000), 1'b1);
    check("soak_count", got, SOAK);
    for (int n = 0; n < N; n++) begin
      check($sformatf("soak_sent%0d", n), sent[n], SOAK);
      check($sformatf("soak_leftover%0d", n), q[n].size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
